flag_branch_unit: RTL and testbench



---
 rtl/flag_branch_unit_if.sv | 35 +++
 rtl/flag_branch_unit.sv | 132 +++++++++++++
 tb/tb_flag_branch_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/flag_branch_unit_if.sv
// Branch request, flag, PC redirect and debug counter bundle for flag_branch_unit.
// master = control unit / flag register / PC side, slave = the branch unit itself.
interface flag_branch_unit_if #(
  parameter int ADDR_W = 16
);
  logic              br_valid;
  logic              br_ready;
  logic [3:0]        br_cond;
  logic [ADDR_W-1:0] br_target;
  logic [3:0]        flags;
  logic              flags_pending;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_target;
  logic              pc_ready;
  logic              br_done;
  logic              br_taken;
  logic [15:0]       taken_count;
  logic [15:0]       nottaken_count;

  modport master (
    output br_valid, br_cond, br_target,
    output flags, flags_pending, pc_ready,
    input  br_ready, pc_load, pc_target,
    input  br_done, br_taken,
    input  taken_count, nottaken_count
  );

  modport slave (
    input  br_valid, br_cond, br_target,
    input  flags, flags_pending, pc_ready,
    output br_ready, pc_load, pc_target,
    output br_done, br_taken,
    output taken_count, nottaken_count
  );
endinterface

// File: rtl/flag_branch_unit.sv
// Conditional branch unit: waits for settled ZCSO flags, evaluates the
// condition, redirects the PC on taken branches and counts outcomes.
// Ports: clock, reset (sync, active-high), bus (flag_branch_unit_if.slave).
module flag_branch_unit #(
  parameter int ADDR_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  flag_branch_unit_if.slave   bus
);
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    REDIRECT
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [3:0]        cond_q;
  logic [ADDR_W-1:0] target_q;
  logic              done_q;
  logic              taken_q;
  logic [15:0]       taken_cnt_q;
  logic [15:0]       nottaken_cnt_q;
  logic              accept;
  logic              eval;
  logic              retire;
  logic              hit;

  // Flags: [0]=Z [1]=C [2]=S [3]=O; signed compares use S^O as "less than".
  function automatic logic cond_hit(
    input logic [3:0] c,
    input logic [3:0] f
  );
    logic z, cy, s, o;
    logic r;
    z  = f[0];
    cy = f[1];
    s  = f[2];
    o  = f[3];
    unique case (c)
      4'b0000: r = 1'b1;
      4'b0001: r = z;
      4'b0010: r = !z;
      4'b0011: r = cy;
      4'b0100: r = !cy;
      4'b0101: r = s;
      4'b0110: r = !s;
      4'b0111: r = o;
      4'b1000: r = !o;
      4'b1001: r = s ^ o;
      4'b1010: r = !(s ^ o);
      4'b1011: r = z | (s ^ o);
      4'b1100: r = !z & !(s ^ o);
      4'b1101: r = cy | z;
      4'b1110: r = !cy & !z;
      4'b1111: r = 1'b0;
    endcase
    return r;
  endfunction

  assign hit = cond_hit(cond_q, bus.flags);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    eval    = 1'b0;
    retire  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.br_valid) begin
          accept  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Flags are only trusted once the in-flight update has landed.
        if (!bus.flags_pending) begin
          eval    = 1'b1;
          state_d = hit ? REDIRECT : IDLE;
        end
      end
      REDIRECT: begin
        if (bus.pc_ready) begin
          retire  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cond_q         <= '0;
      target_q       <= '0;
      done_q         <= 1'b0;
      taken_q        <= 1'b0;
      taken_cnt_q    <= '0;
      nottaken_cnt_q <= '0;
    end else begin
      done_q  <= (eval && !hit) || retire;
      taken_q <= retire;
      if (accept) begin
        cond_q   <= bus.br_cond;
        target_q <= bus.br_target;
      end
      if (eval && hit && taken_cnt_q != 16'hFFFF) begin
        taken_cnt_q <= taken_cnt_q + 16'd1;
      end
      if (eval && !hit && nottaken_cnt_q != 16'hFFFF) begin
        nottaken_cnt_q <= nottaken_cnt_q + 16'd1;
      end
    end
  end

  assign bus.br_ready       = (state == IDLE);
  assign bus.pc_load        = (state == REDIRECT);
  assign bus.pc_target      = target_q;
  assign bus.br_done        = done_q;
  assign bus.br_taken       = taken_q;
  assign bus.taken_count    = taken_cnt_q;
  assign bus.nottaken_count = nottaken_cnt_q;
endmodule

// File: tb/tb_flag_branch_unit.sv
// Scoreboard bench for flag_branch_unit: driver pushes expected outcomes,
// a negedge monitor pops and compares on pc_load / br_done.
module tb_flag_branch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  flag_branch_unit_if #(.ADDR_W(16)) bus ();

  flag_branch_unit #(.ADDR_W(16)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic        taken;
    logic [15:0] target;
    int          done_cyc;
    logic [15:0] tc;
    logic [15:0] nc;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_tc = 0;
  logic [15:0] m_nc = 0;

  // Flags viewed as the outcome of a compare a-b:
  // eq = Z, unsigned below = C, signed less = S xor O.
  function automatic logic ref_taken(
    input logic [3:0] c,
    input logic [3:0] f
  );
    logic z, cy, s, o, lt;
    logic [15:0] tab;
    z  = f[0];
    cy = f[1];
    s  = f[2];
    o  = f[3];
    lt = (s != o);
    tab = {1'b0, !(cy || z), cy || z, !(lt || z), lt || z,
           !lt, lt, !o, o, !s, s, !cy, cy, !z, z, 1'b1};
    return tab[c];
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.pc_load) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL pc_load_unexpected cyc=%0d actual=1 required=0", cyc);
        end else if (!q[0].taken || bus.pc_target !== q[0].target) begin
          failures++;
          $display("FAIL pc_redirect cyc=%0d actual=%h required=%h taken=%0d",
                   cyc, bus.pc_target, q[0].target, q[0].taken);
        end
      end
      if (bus.br_done) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL br_done_spurious cyc=%0d actual=1 required=0", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (bus.br_taken !== e.taken || cyc != e.done_cyc ||
              bus.taken_count !== e.tc || bus.nottaken_count !== e.nc) begin
            failures++;
            $display("FAIL br_done cyc=%0d actual taken=%0d tc=%h nc=%h required taken=%0d cyc=%0d tc=%h nc=%h",
                     cyc, bus.br_taken, bus.taken_count, bus.nottaken_count,
                     e.taken, e.done_cyc, e.tc, e.nc);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    m_tc = 0;
    m_nc = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_pc_load", {31'd0, bus.pc_load}, 32'd0);
    chk("rst_br_done", {31'd0, bus.br_done}, 32'd0);
    chk("rst_br_taken", {31'd0, bus.br_taken}, 32'd0);
    chk("rst_br_ready", {31'd0, bus.br_ready}, 32'd1);
    chk("rst_pc_target", {16'd0, bus.pc_target}, 32'd0);
    chk("rst_taken_cnt", {16'd0, bus.taken_count}, 32'd0);
    chk("rst_nottaken_cnt", {16'd0, bus.nottaken_count}, 32'd0);
    rst = 1'b0;
  endtask

  // abort >= 0: assert reset after that many stalled REDIRECT cycles.
  task automatic branch(input logic [3:0] c, input logic [15:0] t,
                        input logic [3:0] f, input int pend,
                        input int stall, input int abort);
    int   n;
    logic tk;
    exp_t e;
    n = 0;
    while (!bus.br_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.br_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      return;
    end
    bus.br_valid      = 1'b1;
    bus.br_cond       = c;
    bus.br_target     = t;
    bus.flags         = 4'($urandom);
    bus.flags_pending = (pend > 0);
    bus.pc_ready      = (stall == 0);
    tk = ref_taken(c, f);
    if (tk) m_tc = sat_inc(m_tc);
    else    m_nc = sat_inc(m_nc);
    e.taken    = tk;
    e.target   = t;
    e.done_cyc = cyc + 2 + pend + (tk ? 1 + stall : 0);
    e.tc       = m_tc;
    e.nc       = m_nc;
    q.push_back(e);
    @(negedge clk);
    for (int i = 0; i < pend; i++) begin
      chk("wait_ready_low", {31'd0, bus.br_ready}, 32'd0);
      bus.br_valid      = 1'($urandom);
      bus.br_cond       = 4'($urandom);
      bus.br_target     = 16'($urandom);
      bus.flags         = 4'($urandom);
      bus.flags_pending = 1'b1;
      @(negedge clk);
    end
    chk("eval_ready_low", {31'd0, bus.br_ready}, 32'd0);
    bus.br_valid      = 1'b0;
    bus.flags         = f;
    bus.flags_pending = 1'b0;
    @(negedge clk);
    bus.flags = 4'($urandom);
    if (tk) begin
      for (int i = 0; i < stall; i++) begin
        if (i == abort) begin
          do_reset();
          bus.br_valid = 1'b0;
          repeat (6) @(negedge clk);
          return;
        end
        chk("stall_ready_low", {31'd0, bus.br_ready}, 32'd0);
        bus.br_valid  = 1'($urandom);
        bus.br_cond   = 4'($urandom);
        bus.br_target = 16'($urandom);
        @(negedge clk);
      end
      bus.br_valid = 1'b0;
      bus.pc_ready = 1'b1;
    end
    n = 0;
    while (q.size() != 0 && n < stall + 10) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", 32'd0, 32'd1);
      q.delete();
    end
    bus.pc_ready = 1'($urandom);
  endtask

  initial begin
    bus.br_valid      = 1'b0;
    bus.br_cond       = '0;
    bus.br_target     = '0;
    bus.flags         = '0;
    bus.flags_pending = 1'b0;
    bus.pc_ready      = 1'b0;
    do_reset();

    branch(4'b0001, 16'h00A0, 4'b0001, 0, 0, -1);
    chk("t1_taken_cnt", {16'd0, bus.taken_count}, 32'd1);
    branch(4'b0001, 16'h1234, 4'b0000, 0, 0, -1);
    chk("t2_nottaken_cnt", {16'd0, bus.nottaken_count}, 32'd1);
    branch(4'b1001, 16'hBEEF, 4'b0100, 3, 0, -1);
    branch(4'b0000, 16'h5A5A, 4'b0000, 0, 5, -1);

    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        branch(4'(c), 16'($urandom), 4'(f), 0, 0, -1);
      end
    end

    for (int k = 0; k < 150; k++) begin
      branch(4'($urandom), 16'($urandom), 4'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end

    branch(4'b0000, 16'hC0DE, 4'b0000, 1, 5, 2);
    chk("abort_taken_cnt", {16'd0, bus.taken_count}, 32'd0);
    chk("abort_pc_load", {31'd0, bus.pc_load}, 32'd0);

    force dut.taken_cnt_q = 16'hFFFE;
    force dut.nottaken_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.taken_cnt_q;
    release dut.nottaken_cnt_q;
    m_tc = 16'hFFFE;
    m_nc = 16'hFFFE;
    branch(4'b0000, 16'h0F0F, 4'b0000, 0, 0, -1);
    branch(4'b0000, 16'hF0F0, 4'b0000, 0, 0, -1);
    chk("sat_taken_cnt", {16'd0, bus.taken_count}, 32'h0000FFFF);
    branch(4'b1111, 16'h0001, 4'b0000, 0, 0, -1);
    branch(4'b1111, 16'h0002, 4'b1111, 0, 0, -1);
    chk("sat_nottaken_cnt", {16'd0, bus.nottaken_count}, 32'h0000FFFF);

    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
